// File: rtl/mult_seq_nibble.sv
// rtl/mult_seq_nibble.sv - sequential signed/unsigned multiplier, one 4x4 nibble product per cycle
module mult_seq_nibble #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    input  logic                 is_signed,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   P,
    output logic                 busy
);

    localparam int K  = WIDTH / 4;
    localparam int IW = (K > 1) ? $clog2(K) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t               state;
    logic [IW-1:0]        i;
    logic [IW-1:0]        j;
    logic [WIDTH-1:0]     mag_a;
    logic [WIDTH-1:0]     mag_b;
    logic                 neg;
    logic [2*WIDTH-1:0]   acc;

    logic [3:0]           nib_a;
    logic [3:0]           nib_b;
    logic [7:0]           pp;
    logic [2*WIDTH-1:0]   pp_shift;
    logic [2*WIDTH-1:0]   sum;
    logic                 last;

    // The single shared 4x4 multiplier; its product is aligned by the nibble weights.
    always_comb begin
        nib_a    = mag_a[4*i +: 4];
        nib_b    = mag_b[4*j +: 4];
        pp       = nib_a * nib_b;
        pp_shift = (2*WIDTH)'(pp) << (4 * (int'(i) + int'(j)));
        sum      = acc + pp_shift;
        last     = (i == IW'(K-1)) && (j == IW'(K-1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            P         <= '0;
            acc       <= '0;
            i         <= '0;
            j         <= '0;
            neg       <= 1'b0;
            mag_a     <= '0;
            mag_b     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        // Magnitudes stay WIDTH-bit unsigned so the most negative value fits.
                        mag_a    <= (is_signed && A[WIDTH-1]) ? -A : A;
                        mag_b    <= (is_signed && B[WIDTH-1]) ? -B : B;
                        neg      <= is_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
                        acc      <= '0;
                        i        <= '0;
                        j        <= '0;
                        state    <= RUN;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                RUN: begin
                    acc <= sum;
                    if (last) begin
                        P         <= neg ? -sum : sum;
                        i         <= '0;
                        j         <= '0;
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end else if (j == IW'(K-1)) begin
                        j <= '0;
                        i <= i + IW'(1);
                    end else begin
                        j <= j + IW'(1);
                    end
                end
                DONE: begin
                    // Leaving DONE never accepts; in_ready only rises on the next cycle.
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_seq_nibble.sv
// tb/tb_mult_seq_nibble.sv - directed and randomized checks of mult_seq_nibble at WIDTH 8 and 16
module tb_mult_seq_nibble;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        iv8 = 0, ir8, s8 = 0, ov8, or8 = 0, busy8;
    logic [7:0]  a8 = 0, b8 = 0;
    logic [15:0] p8;

    logic        iv16 = 0, ir16, s16 = 0, ov16, or16 = 0, busy16;
    logic [15:0] a16 = 0, b16 = 0;
    logic [31:0] p16;

    int tests = 0;
    int fails = 0;

    mult_seq_nibble #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .A(a8), .B(b8),
        .is_signed(s8), .out_valid(ov8), .out_ready(or8), .P(p8), .busy(busy8)
    );

    mult_seq_nibble #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .A(a16), .B(b16),
        .is_signed(s16), .out_valid(ov16), .out_ready(or16), .P(p16), .busy(busy16)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic s, input logic [15:0] exp);
        int cnt;
        @(negedge clk);
        a8 = a; b8 = b; s8 = s; iv8 = 1;
        check({tag, " in_ready"}, 64'(ir8), 64'd1);
        @(posedge clk);
        @(negedge clk);
        iv8 = 0; a8 = ~a; b8 = ~b; s8 = ~s;
        cnt = 0;
        while (!ov8 && cnt < 40) begin
            @(posedge clk);
            cnt++;
            @(negedge clk);
        end
        check({tag, " latency"}, 64'(cnt), 64'd4);
        check({tag, " P"}, 64'(p8), 64'(exp));
        check({tag, " in_ready in DONE"}, 64'(ir8), 64'd0);
        or8 = 1;
        @(posedge clk);
        @(negedge clk);
        or8 = 0;
        check({tag, " in_ready after"}, 64'(ir8), 64'd1);
    endtask

    task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic s);
        int cnt;
        logic [31:0] exp;
        exp = s ? $signed({{16{a[15]}}, a}) * $signed({{16{b[15]}}, b})
                : {16'b0, a} * {16'b0, b};
        @(negedge clk);
        a16 = a; b16 = b; s16 = s; iv16 = 1;
        @(posedge clk);
        @(negedge clk);
        iv16 = 0;
        cnt = 0;
        while (!ov16 && cnt < 60) begin
            a16 = 16'($urandom); b16 = 16'($urandom); s16 = 1'($urandom_range(0, 1));
            @(posedge clk);
            cnt++;
            @(negedge clk);
        end
        check("w16 latency", 64'(cnt), 64'd16);
        if (p16 !== exp)
            $display("  operands a=%0h b=%0h signed=%0d", a, b, s);
        check("w16 P", 64'(p16), 64'(exp));
        or16 = 1;
        @(posedge clk);
        @(negedge clk);
        or16 = 0;
    endtask

    initial begin
        int cnt;
        @(negedge clk);
        @(negedge clk);
        check("rst in_ready", 64'(ir8), 64'd1);
        check("rst out_valid", 64'(ov8), 64'd0);
        check("rst busy", 64'(busy8), 64'd0);
        check("rst P", 64'(p8), 64'd0);
        check("rst w16 in_ready", 64'(ir16), 64'd1);
        rst = 0;

        op8("u255x255", 8'hFF, 8'hFF, 1'b0, 16'hFE01);
        op8("s-128x-128", 8'h80, 8'h80, 1'b1, 16'h4000);
        op8("s-3x5", 8'hFD, 8'h05, 1'b1, 16'hFFF1);
        op8("s-5x0", 8'hFB, 8'h00, 1'b1, 16'h0000);
        op8("u0x0", 8'h00, 8'h00, 1'b0, 16'h0000);
        op8("s127x-128", 8'h7F, 8'h80, 1'b1, 16'hC080);
        op8("u128x2", 8'h80, 8'h02, 1'b0, 16'h0100);
        op8("s-1x-1", 8'hFF, 8'hFF, 1'b1, 16'h0001);

        // backpressure: hold DONE three cycles with a new request waiting
        @(negedge clk);
        a8 = 8'h0F; b8 = 8'h0F; s8 = 0; iv8 = 1;
        @(posedge clk);
        @(negedge clk);
        a8 = 8'd3; b8 = 8'd4;
        cnt = 0;
        while (!ov8 && cnt < 40) begin
            @(posedge clk);
            cnt++;
            @(negedge clk);
        end
        check("bp latency", 64'(cnt), 64'd4);
        for (int k = 0; k < 3; k++) begin
            check("bp P stable", 64'(p8), 64'd225);
            check("bp in_ready", 64'(ir8), 64'd0);
            check("bp out_valid", 64'(ov8), 64'd1);
            @(posedge clk);
            @(negedge clk);
        end
        or8 = 1;
        @(posedge clk);
        @(negedge clk);
        or8 = 0;
        check("bp no accept on leave", 64'(busy8), 64'd0);
        check("bp in_ready after", 64'(ir8), 64'd1);
        @(posedge clk);
        @(negedge clk);
        iv8 = 0;
        cnt = 0;
        while (!ov8 && cnt < 40) begin
            @(posedge clk);
            cnt++;
            @(negedge clk);
        end
        check("bp2 latency", 64'(cnt), 64'd4);
        check("bp2 P", 64'(p8), 64'd12);
        or8 = 1;
        @(posedge clk);
        @(negedge clk);
        or8 = 0;

        // reset two edges into an operation
        a8 = 8'h12; b8 = 8'h34; s8 = 0; iv8 = 1;
        @(posedge clk);
        @(negedge clk);
        iv8 = 0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1;
        @(negedge clk);
        check("mid-rst busy", 64'(busy8), 64'd0);
        check("mid-rst P", 64'(p8), 64'd0);
        check("mid-rst in_ready", 64'(ir8), 64'd1);
        rst = 0;
        cnt = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (ov8) cnt++;
        end
        check("mid-rst no out_valid", 64'(cnt), 64'd0);
        op8("after-rst 7x9", 8'd7, 8'd9, 1'b0, 16'd63);

        op16(16'h8000, 16'h8000, 1'b1);
        op16(16'hFFFF, 16'hFFFF, 1'b0);
        for (int k = 0; k < 1000; k++)
            op16(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
